pc_seq: RTL
===========

# pc_seq

Parametrised program-counter sequencer for the processor fetch path. It replaces the fixed-width PC, its jump lookup table and the hard-wired `done` compare with one block. The block adds a start/done handshake, a stall input, a writable jump-target LUT, conditional branches and a call/return stack. Its output `prog_ctr` addresses the instruction ROM; the control decoder supplies `op`, `lut_idx` and `cond`.

## Interface
- `D`, 12, program counter width
- `LA`, 5, LUT address width; the LUT has 2^LA entries of D bits
- `S`, 4, return stack depth (≥1)
- `HALT_ADDR`, 128, PC value that terminates a run

Ports:
- `clk`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run at `start_addr`; sampled in IDLE or DONE only
- `start_addr`  in  D  first PC of a run
- `stall`  in  1  freezes sequencing while in RUN
- `op`  in  3  sequencing op: 0 NEXT, 1 JREL, 2 JABS, 3 BREL, 4 CALL, 5 RET, 6 HALT, 7 treated as NEXT
- `lut_idx`  in  LA  LUT entry used by jump ops
- `cond`  in  1  branch flag (registered flag from the ALU) for BREL
- `lut_we`  in  1  LUT write enable
- `lut_waddr`  in  LA  LUT write index
- `lut_wdata`  in  D  LUT write data
- `prog_ctr`  out  D  current PC (registered)
- `running`  out  1  high in RUN
- `done`  out  1  high in DONE
- `err`  out  1  sticky stack fault, cleared by `start`

## Operation
- State machine IDLE → RUN → DONE.
  - IDLE/DONE with `start`=1 → RUN.
  - RUN → DONE on HALT, on a stack fault, or when the computed next PC equals `HALT_ADDR`.
  - DONE returns to RUN only through `start`.
- On `start` in IDLE/DONE:
  - `prog_ctr`←`start_addr`.
  - Stack emptied.
  - `err`←0.
- `start` is ignored in RUN.
- Next PC in RUN with `stall`=0, where T=LUT[`lut_idx`]:
  - NEXT: pc+1.
  - JREL: pc+T, with T as D-bit two's complement.
  - JABS: T.
  - BREL: pc+T if `cond`=1, else pc+1.
  - CALL: push pc+1, then PC←T.
  - RET: PC←pop.
  - HALT: PC unchanged, go to DONE.
- Arithmetic is modulo 2^D; wrap-around is silent (0xFFF+1 → 0x000 at D=12).
- If the computed next PC == `HALT_ADDR`: `prog_ctr` takes that value and the state goes to DONE.
- Stack faults (both set `err`←1 and go to DONE):
  - CALL with S entries already on the stack: push discarded, PC unchanged.
  - RET with an empty stack: PC unchanged.
- `stall`=1 in RUN holds the PC, the stack and the state; `op` is ignored.
- `stall` has no effect in IDLE or DONE.
- LUT write: synchronous when `lut_we`=1, in any state. Read is combinational. A same-cycle read and write of the same index returns the old entry.

## Timing
- Reset values: `prog_ctr`=0, `running`=0, `done`=0, `err`=0, stack empty, all LUT entries 0, state IDLE.
- `reset` asserted mid-run forces these values immediately, without waiting for a clock edge.
- Latency:
  - An op presented in cycle n produces the new `prog_ctr` after edge n+1.
  - One op per cycle, no bubbles.
- `start` sampled at edge n: `running`=1 and `prog_ctr`=`start_addr` after that edge.
- `done`/`err` rise on the same edge that commits the terminating PC.
- `done` holds until `start` or `reset`.
- `running` and `done` are never both 1.

## Test plan
- Reset, then `start`, `start_addr`=0x010, 5× NEXT → `prog_ctr` steps 0x010..0x015; `running`=1, `done`=0.
- LUT[3]=0xFFE (−2); at pc 0x020 issue JREL idx 3 → 0x01E. Same entry via BREL: `cond`=0 → 0x021; `cond`=1 → 0x01E.
- With S=4: 4× CALL to LUT targets, then 4× RET → return addresses come back in LIFO order. A 5th CALL → `err`=1, `done`=1, PC unchanged. Restart, then RET on an empty stack → `err`=1.
- NEXT from pc 0x07F → `prog_ctr`=0x080, `done`=1 on that edge. `start` with `start_addr`=0 → `done`=0, `err`=0, RUN at 0.
- `stall`=1 for 3 cycles during JABS → PC frozen 3 cycles, jump committed on the first edge with `stall`=0. Then `reset` pulsed low mid-run → all outputs 0 immediately.
- `lut_we` to idx 5 with JABS idx 5 in the same cycle → old target is used. The same op on the next cycle → new target is used.

Source files
------------

// File: rtl/pc_seq.sv
// Program-counter sequencer: start/done handshake, stall, writable jump-target LUT,
// conditional branches and a bounded call/return stack.
module pc_seq #(
  parameter int unsigned D         = 12,
  parameter int unsigned LA        = 5,
  parameter int unsigned S         = 4,
  parameter int unsigned HALT_ADDR = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic [2:0]    op,
  input  logic [LA-1:0] lut_idx,
  input  logic          cond,
  input  logic          lut_we,
  input  logic [LA-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic          err
);

  localparam int unsigned Entries = 2 ** LA;
  localparam int unsigned SpW     = $clog2(S + 1);
  localparam int unsigned IdxW    = (S > 1) ? $clog2(S) : 1;

  localparam logic [SpW-1:0] SpFull = SpW'(S);
  localparam logic [SpW-1:0] SpOne  = SpW'(1);
  localparam logic [D-1:0]   HaltPc = D'(HALT_ADDR);
  localparam logic [D-1:0]   PcOne  = D'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef enum logic [2:0] {
    OpNext, OpJrel, OpJabs, OpBrel, OpCall, OpRet, OpHalt, OpRsvd
  } op_e;

  state_e          state_q, state_d;
  logic [D-1:0]    pc_q, pc_d;
  logic [SpW-1:0]  sp_q, sp_d;
  logic            err_q, err_d;
  logic [D-1:0]    lut_q [Entries];
  logic [D-1:0]    stk_q [S];

  logic [D-1:0]    lut_rd;
  logic [D-1:0]    pc_inc;
  logic [SpW-1:0]  sp_dec;
  logic [IdxW-1:0] push_idx;
  logic [IdxW-1:0] pop_idx;
  logic            push;
  logic            fault;

  // Combinational read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign lut_rd   = lut_q[lut_idx];
  assign pc_inc   = pc_q + PcOne;
  assign sp_dec   = sp_q - SpOne;
  assign push_idx = sp_q[IdxW-1:0];
  assign pop_idx  = sp_dec[IdxW-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
    fault   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          pc_d    = start_addr;
          sp_d    = '0;
          err_d   = 1'b0;
        end
      end

      StRun: begin
        if (!stall) begin
          case (op_e'(op))
            OpJrel: pc_d = pc_q + lut_rd;
            OpJabs: pc_d = lut_rd;
            OpBrel: pc_d = cond ? (pc_q + lut_rd) : pc_inc;
            OpCall: begin
              if (sp_q == SpFull) begin
                fault = 1'b1;
              end else begin
                push = 1'b1;
                sp_d = sp_q + SpOne;
                pc_d = lut_rd;
              end
            end
            OpRet: begin
              if (sp_q == '0) begin
                fault = 1'b1;
              end else begin
                sp_d = sp_dec;
                pc_d = stk_q[pop_idx];
              end
            end
            OpHalt:  state_d = StDone;
            default: pc_d = pc_inc;
          endcase

          // A faulting op leaves the PC where it was.
          if (fault) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (pc_d == HaltPc) begin
            state_d = StDone;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(S); i++) begin
        stk_q[i] <= '0;
      end
    end else if (push) begin
      stk_q[push_idx] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(Entries); i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign prog_ctr = pc_q;
  assign running  = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign err      = err_q;

endmodule
